// File: rtl/mod113_residue_accumulator_pkg.sv
// Shared mod-113 definitions: modulus, residue type and the one-subtract modular add.
package mod113_pkg;

  localparam int MOD = 113;
  localparam int RW  = 7;

  typedef logic [RW-1:0] res_t;

  // Both operands are already reduced, so their sum is below 2*MOD and one
  // conditional subtract brings it back into [0, MOD-1].
  function automatic res_t mod_add(input res_t a, input res_t b);
    logic [RW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (RW+1)'(MOD)) begin
      s = s - (RW+1)'(MOD);
    end
    return s[RW-1:0];
  endfunction

endpackage

// File: rtl/mod113_residue_accumulator_mod_add_113.sv
// Combinational mod-113 adder of two reduced residues.
module mod_add_113
  import mod113_pkg::*;
(
  input  res_t a,
  input  res_t b,
  output res_t y
);

  assign y = mod_add(a, b);

endmodule

// File: rtl/mod113_residue_accumulator.sv
// Streams LANES residues per beat, folds them mod 113 across an in_last-delimited
// message and presents one 7-bit residue (plus an out-of-range flag) per message.
module mod113_residue_accumulator
  import mod113_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*RW-1:0] in_res,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RW-1:0]       out_res,
  output logic                out_err
);

  localparam int LEVELS = $clog2(LANES);

  // Sanitised lanes: codes 113..127 cannot come from a healthy LUT stage, so
  // they contribute nothing to the sum and only raise the error flag.
  res_t             w_lane [LANES];
  logic [LANES-1:0] w_lane_err;
  res_t             w_beat_sum;
  logic             w_beat_err;
  res_t             w_acc_next;
  logic             w_stall;
  logic             w_s1_adv;
  logic             w_in_fire;

  logic             r_ready_en;
  logic             r_s1_valid;
  res_t             r_s1_sum;
  logic             r_s1_last;
  logic             r_s1_err;
  res_t             r_acc;
  logic             r_err_acc;
  logic             r_out_valid;
  res_t             r_out_res;
  logic             r_out_err;

  genvar gi;
  genvar gl;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_err[gi] = (in_res[gi*RW +: RW] >= RW'(MOD));
      assign w_lane[gi]     = w_lane_err[gi] ? '0 : in_res[gi*RW +: RW];
    end

    // Balanced reduction tree: level gl halves the number of partial sums.
    for (gl = 0; gl < LEVELS; gl++) begin : g_lvl
      localparam int N = LANES >> (gl + 1);
      res_t w_sum [N];
      for (gi = 0; gi < N; gi++) begin : g_add
        res_t w_a;
        res_t w_b;
        if (gl == 0) begin : g_leaf
          assign w_a = w_lane[2*gi];
          assign w_b = w_lane[2*gi+1];
        end else begin : g_inner
          assign w_a = g_lvl[gl-1].w_sum[2*gi];
          assign w_b = g_lvl[gl-1].w_sum[2*gi+1];
        end
        mod_add_113 u_add (.a(w_a), .b(w_b), .y(w_sum[gi]));
      end
    end
  endgenerate

  assign w_beat_sum = g_lvl[LEVELS-1].w_sum[0];
  assign w_beat_err = |w_lane_err;

  mod_add_113 u_acc_add (.a(r_acc), .b(r_s1_sum), .y(w_acc_next));

  // Only a closing beat can be blocked, and only by an unread result.
  assign w_stall   = r_s1_valid && r_s1_last && r_out_valid && !out_ready;
  assign w_s1_adv  = r_s1_valid && !w_stall;
  assign in_ready  = r_ready_en && !w_stall;
  assign w_in_fire = in_valid && in_ready;

  // Hold off input acceptance until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ready_en <= 1'b0;
    else        r_ready_en <= 1'b1;
  end

  // S1: capture the reduced beat; an idle or advancing S1 is always refilled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_last  <= 1'b0;
      r_s1_err   <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_in_fire) begin
        r_s1_sum  <= w_beat_sum;
        r_s1_last <= in_last;
        r_s1_err  <= w_beat_err;
      end
    end
  end

  // S2 accumulator: fold mid-message beats, restart after the closing beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_err_acc <= 1'b0;
    end else if (w_s1_adv) begin
      if (r_s1_last) begin
        r_acc     <= '0;
        r_err_acc <= 1'b0;
      end else begin
        r_acc     <= w_acc_next;
        r_err_acc <= r_err_acc | r_s1_err;
      end
    end
  end

  // Output register: drain on out_ready; a new result in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
      r_out_err   <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_s1_adv && r_s1_last) begin
        r_out_valid <= 1'b1;
        r_out_res   <= w_acc_next;
        r_out_err   <= r_err_acc | r_s1_err;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;
  assign out_err   = r_out_err;

endmodule
